rls_sample_sequencer: RTL and testbench

- Producer side of the RLS measurement interface: buffers incoming measurement samples and drives the RLS `y`/`newIt` inputs, one `newIt` strobe per sample.
- Spaces strobes by a fixed iteration budget. At the end of each iteration it captures the RLS estimate vector `x` and presents it with a one-cycle valid pulse.
- Sits between the upstream sample source (ADC front end or host register block) and the RLS core.

---
 rtl/rls_sample_sequencer.sv | 145 ++++++++++++++
 tb/tb_rls_sample_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rls_sample_sequencer.sv
// rls_sample_sequencer: producer side of the RLS measurement interface.
// Buffers upstream samples in a small FIFO and issues one newIt strobe per
// sample. After each strobe it waits ITER_CYCLES for the RLS core, then
// captures its estimate vector x_in and presents it with a one-cycle pulse.
module rls_sample_sequencer #(
   parameter int nBits       = 32,
   parameter int N           = 2,
   parameter int DEPTH       = 4,
   parameter int ITER_CYCLES = 50
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [nBits-1:0]             s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [nBits-1:0]             y,
   output logic                         newIt,
   input  logic [N*nBits-1:0]           x_in,
   output logic [N*nBits-1:0]           est_out,
   output logic                         est_valid,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fill
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH+1);
   localparam int CW = $clog2(ITER_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [nBits-1:0]     mem_q [DEPTH];
   logic [nBits-1:0]     mem_d [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]        fill_q, fill_d;
   logic [nBits-1:0]     y_q, y_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [N*nBits-1:0]   est_out_q, est_out_d;
   logic                 est_valid_q, est_valid_d;

   logic push, pop;

   // Handshake: ready depends on registered fill only, pop only when leaving IDLE
   always_comb begin
      s_ready = (fill_q != FW'(DEPTH));
      push    = s_valid && s_ready;
      pop     = (state_q == S_IDLE) && (fill_q != '0);
   end

   // All state flops; reset aborts any iteration and discards FIFO contents
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         y_q         <= '0;
         cnt_q       <= '0;
         est_out_q   <= '0;
         est_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         y_q         <= y_d;
         cnt_q       <= cnt_d;
         est_out_q   <= est_out_d;
         est_valid_q <= est_valid_d;
      end
   end

   // FIFO: pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push) begin
         mem_d[wr_ptr_q] = s_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pop) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (cnt_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: y loads only on entry to ISSUE; the estimate is captured on the
   // edge that brings the counter to zero, so est_valid/est_out are visible
   // during the final WAIT cycle, ITER_CYCLES after the strobe.
   always_comb begin
      y_d         = y_q;
      cnt_d       = cnt_q;
      est_out_d   = est_out_q;
      est_valid_d = 1'b0;
      case (state_q)
         S_IDLE:  if (pop) y_d = mem_q[rd_ptr_q];
         S_ISSUE: cnt_d = CW'(ITER_CYCLES - 1);
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  est_out_d   = x_in;
                  est_valid_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from registered state
   always_comb begin
      newIt     = (state_q == S_ISSUE);
      busy      = (state_q != S_IDLE);
      y         = y_q;
      est_out   = est_out_q;
      est_valid = est_valid_q;
      fill      = fill_q;
   end

endmodule

// File: tb/tb_rls_sample_sequencer.sv
// Scoreboard bench for rls_sample_sequencer: accepted samples are queued and
// checked against y at each newIt strobe; estimate pulses are checked for
// timing relative to the last strobe and for content.
module tb_rls_sample_sequencer;
   localparam int NB    = 32;
   localparam int N     = 2;
   localparam int DEPTH = 4;
   localparam int ITER  = 50;
   localparam int FW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NB-1:0]   s_data = '0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [NB-1:0]   y;
   logic            newIt;
   logic [N*NB-1:0] x_in = '0;
   logic [N*NB-1:0] est_out;
   logic            est_valid;
   logic            busy;
   logic [FW-1:0]   fill;

   rls_sample_sequencer #(.nBits(NB), .N(N), .DEPTH(DEPTH), .ITER_CYCLES(ITER)) dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .y(y), .newIt(newIt), .x_in(x_in), .est_out(est_out), .est_valid(est_valid),
      .busy(busy), .fill(fill)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            errors = 0, checks = 0;
   logic [NB-1:0] exp_y [$];
   int            strobe_cyc [$];
   int            n_strobe = 0, n_est = 0, last_strobe = -100000;
   logic          prev_newit = 1'b0, prev_estv = 1'b0;
   logic [NB-1:0] y_at_strobe = '0;

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [NB-1:0] e;
      if (reset) begin
         prev_newit = 1'b0;
         prev_estv  = 1'b0;
      end else begin
         if (newIt) begin
            checks++;
            if (exp_y.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_strobe: y=%h at cycle %0d, required no strobe", y, cyc);
            end else begin
               e = exp_y.pop_front();
               if (y !== e) begin
                  errors++;
                  $display("FAIL sb_y: got %h required %h at cycle %0d", y, e, cyc);
               end
            end
            checks++;
            if (prev_newit) begin
               errors++;
               $display("FAIL newit_consecutive: newIt high two cycles at %0d", cyc);
            end
            n_strobe++;
            strobe_cyc.push_back(cyc);
            last_strobe = cyc;
            y_at_strobe = y;
         end else if (busy) begin
            checks++;
            if (y !== y_at_strobe) begin
               errors++;
               $display("FAIL y_stable: got %h required %h at cycle %0d", y, y_at_strobe, cyc);
            end
         end
         if (est_valid) begin
            checks++;
            if (cyc - last_strobe != ITER) begin
               errors++;
               $display("FAIL est_timing: est_valid %0d cycles after strobe, required %0d", cyc - last_strobe, ITER);
            end
            checks++;
            if (est_out !== x_in) begin
               errors++;
               $display("FAIL est_data: got %h required %h", est_out, x_in);
            end
            checks++;
            if (prev_estv) begin
               errors++;
               $display("FAIL est_pulse_width: est_valid high two cycles at %0d", cyc);
            end
            n_est++;
         end
         prev_newit = newIt;
         prev_estv  = est_valid;
      end
   end

   // Drive one sample for one cycle; caller is at a negedge, returns at the next
   task automatic push_one(input logic [NB-1:0] d, output int pc, output bit acc);
      s_valid = 1'b1;
      s_data  = d;
      pc      = cyc;
      acc     = s_ready;
      if (acc) exp_y.push_back(d);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_strobes(input int target, input int limit, input string nm);
      int k = 0;
      while (n_strobe < target && k < limit) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (n_strobe < target) begin
         errors++;
         $display("FAIL %s_timeout: strobes %0d required %0d", nm, n_strobe, target);
      end
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while ((busy || fill != 0) && k < 8 * (ITER + 2)) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (busy || fill != 0) begin
         errors++;
         $display("FAIL %s_idle_timeout: busy=%0b fill=%0d required 0/0", nm, busy, fill);
      end
   endtask

   task automatic test_reset();
      int n0;
      @(negedge clk);
      reset = 1'b1;
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_y.delete();
      last_strobe = -100000;
      checks += 7;
      if (s_ready !== 1'b1)   begin errors++; $display("FAIL rst_s_ready: got %b required 1", s_ready); end
      if (y !== '0)           begin errors++; $display("FAIL rst_y: got %h required 0", y); end
      if (newIt !== 1'b0)     begin errors++; $display("FAIL rst_newIt: got %b required 0", newIt); end
      if (est_out !== '0)     begin errors++; $display("FAIL rst_est_out: got %h required 0", est_out); end
      if (est_valid !== 1'b0) begin errors++; $display("FAIL rst_est_valid: got %b required 0", est_valid); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
      if (fill !== '0)        begin errors++; $display("FAIL rst_fill: got %0d required 0", fill); end
      n0 = n_strobe;
      repeat (20) @(negedge clk);
      checks++;
      if (n_strobe != n0) begin errors++; $display("FAIL rst_idle_strobe: got %0d strobes required 0", n_strobe - n0); end
   endtask

   task automatic test_single(input logic [N*NB-1:0] xv, input string nm);
      int pc, k;
      bit acc;
      x_in = xv;
      push_one(32'h00060000, pc, acc);
      checks += 2;
      if (!acc)           begin errors++; $display("FAIL %s_accept: got 0 required 1", nm); end
      if (newIt !== 1'b0) begin errors++; $display("FAIL %s_newit_p1: got %b required 0", nm, newIt); end
      @(negedge clk);
      checks++;
      if (newIt !== 1'b1 || y !== 32'h00060000) begin
         errors++;
         $display("FAIL %s_newit_p2: got newIt=%b y=%h required 1/00060000", nm, newIt, y);
      end
      k = 0;
      while (!est_valid && k < ITER + 20) begin
         @(negedge clk);
         k++;
      end
      checks += 2;
      if (!est_valid) begin
         errors++;
         $display("FAIL %s_est_timeout: no est_valid", nm);
      end else if (cyc != pc + 2 + ITER) begin
         errors++;
         $display("FAIL %s_est_cycle: got %0d required %0d", nm, cyc, pc + 2 + ITER);
      end
      if (est_out !== xv) begin errors++; $display("FAIL %s_est_out: got %h required %h", nm, est_out, xv); end
      wait_idle(nm);
   endtask

   task automatic test_back_to_back();
      int pc, p2, s0, n0;
      bit a1, a2;
      x_in = 64'h00030000_FFFF8000;
      s0 = strobe_cyc.size();
      n0 = n_strobe;
      push_one(32'h00060000, pc, a1);
      push_one(32'h00070000, p2, a2);
      checks++;
      if (!(a1 && a2)) begin errors++; $display("FAIL b2b_accept: got %b%b required 11", a1, a2); end
      wait_strobes(n0 + 2, 3 * (ITER + 2), "b2b");
      if (strobe_cyc.size() >= s0 + 2) begin
         checks += 2;
         if (strobe_cyc[s0] != pc + 2) begin
            errors++; $display("FAIL b2b_first: got %0d required %0d", strobe_cyc[s0], pc + 2);
         end
         if (strobe_cyc[s0+1] - strobe_cyc[s0] != ITER + 2) begin
            errors++; $display("FAIL b2b_period: got %0d required %0d", strobe_cyc[s0+1] - strobe_cyc[s0], ITER + 2);
         end
      end
      wait_idle("b2b");
   endtask

   task automatic test_fill_limit();
      int acc_n = 0, n0;
      x_in = 64'h12345678_9ABCDEF0;
      n0 = n_strobe;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = 32'h00100000 + i;
         if (s_ready) begin
            acc_n++;
            exp_y.push_back(s_data);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      checks += 2;
      if (acc_n != 5) begin errors++; $display("FAIL full_accept: got %0d required 5", acc_n); end
      if (fill !== FW'(4) || s_ready !== 1'b0) begin
         errors++; $display("FAIL full_ready: got fill=%0d s_ready=%b required 4/0", fill, s_ready);
      end
      wait_strobes(n0 + 5, 6 * (ITER + 2), "full");
      checks++;
      if (exp_y.size() != 0) begin errors++; $display("FAIL full_leftover: got %0d required 0", exp_y.size()); end
      wait_idle("full");
   endtask

   task automatic test_wrap();
      int pc, k, n0;
      bit acc;
      x_in = 64'h0000C000_00018000;
      n0 = n_strobe;
      for (int i = 0; i < 3; i++) push_one(32'h00200000 + i, pc, acc);
      checks++;
      if (fill !== FW'(2)) begin errors++; $display("FAIL wrap_prefill: got %0d required 2", fill); end
      k = 0;
      while (busy && k < 2 * ITER) begin
         @(negedge clk);
         k++;
      end
      push_one(32'h00200003, pc, acc);
      checks += 2;
      if (!acc)            begin errors++; $display("FAIL wrap_pushpop_accept: got 0 required 1"); end
      if (fill !== FW'(2)) begin errors++; $display("FAIL wrap_pushpop_fill: got %0d required 2", fill); end
      push_one(32'h00200004, pc, acc);
      push_one(32'h00200005, pc, acc);
      wait_strobes(n0 + 6, 8 * (ITER + 2), "wrap");
      checks++;
      if (exp_y.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d required 0", exp_y.size()); end
      wait_idle("wrap");
   endtask

   task automatic test_reset_mid();
      int pc, e0, s0;
      bit acc;
      x_in = 64'h00050000_00040000;
      for (int i = 0; i < 4; i++) push_one(32'h00300000 + i, pc, acc);
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || fill !== FW'(3)) begin
         errors++; $display("FAIL mid_setup: got busy=%b fill=%0d required 1/3", busy, fill);
      end
      e0 = n_est;
      reset = 1'b1;
      exp_y.delete();
      @(negedge clk);
      reset = 1'b0;
      last_strobe = -100000;
      s0 = n_strobe;
      checks += 4;
      if (fill !== '0)        begin errors++; $display("FAIL mid_fill: got %0d required 0", fill); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
      if (newIt !== 1'b0)     begin errors++; $display("FAIL mid_newit: got %b required 0", newIt); end
      if (s_ready !== 1'b1)   begin errors++; $display("FAIL mid_ready: got %b required 1", s_ready); end
      repeat (ITER + 10) @(negedge clk);
      checks += 2;
      if (n_est != e0)    begin errors++; $display("FAIL mid_est: got %0d pulses required 0", n_est - e0); end
      if (n_strobe != s0) begin errors++; $display("FAIL mid_strobe: got %0d strobes required 0", n_strobe - s0); end
      test_single(64'h00010000_00020000, "post_rst");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single(64'h0000C000_00018000, "single");
      test_back_to_back();
      test_fill_limit();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
